// File: rtl/mips_pipe_pkg.sv
// Shared types for the pipeline hazard controller: per-stage record, bubble constant
// and the forwarding-select width helper.
package mips_pipe_pkg;

  // Record register field is sized for the widest supported register file; narrower
  // register addresses are zero-extended into it.
  localparam int MAX_REG_AW = 8;

  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic [MAX_REG_AW-1:0] wr_reg;
    logic                  is_load;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '0;

  function automatic int sel_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding source selector for one operand: picks the youngest eligible producer
// among the tracked stages; 0 selects the register file.
module fwd_select
  import mips_pipe_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SW    = sel_width(DEPTH)
) (
  input  stage_rec_t [DEPTH-1:0] stages,
  input  logic [MAX_REG_AW-1:0]  src,
  output logic [SW-1:0]          sel
);

  logic [DEPTH-1:0] match;

  // A load still in stage 0 has no data yet; that case is covered by the stall.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match[gi] = stages[gi].valid && stages[gi].wr_en &&
                       (stages[gi].wr_reg != '0) && (stages[gi].wr_reg == src) &&
                       !(stages[gi].is_load && (gi == 0));
  end

  always_comb begin
    sel = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match[k]) sel = SW'(k + 1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and operand forwarding.
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int BR_STAGE = 1,
  localparam int SW      = sel_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_wr_reg,
  input  logic              br_taken,
  output logic              stall,
  output logic              flush,
  output logic [SW-1:0]     fwd_a_sel,
  output logic [SW-1:0]     fwd_b_sel,
  output logic [DEPTH-1:0]  stage_valid
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  stage_rec_t [DEPTH-1:0] stage_reg;
  stage_rec_t [DEPTH-1:0] stage_next;
  stage_rec_t             id_rec;
  logic [MAX_REG_AW-1:0]  rs_ext;
  logic [MAX_REG_AW-1:0]  rt_ext;
  logic                   rs_hit;
  logic                   rt_hit;
  logic                   load_use;

  assign rs_ext = MAX_REG_AW'(id_rs);
  assign rt_ext = MAX_REG_AW'(id_rt);

  always_comb begin
    id_rec         = BUBBLE;
    id_rec.valid   = 1'b1;
    id_rec.wr_en   = id_wr_en;
    id_rec.wr_reg  = MAX_REG_AW'(id_wr_reg);
    id_rec.is_load = id_is_load;
  end

  assign rs_hit   = id_uses_rs && (rs_ext == stage_reg[0].wr_reg);
  assign rt_hit   = id_uses_rt && (rt_ext == stage_reg[0].wr_reg);
  assign load_use = id_valid && stage_reg[0].valid && stage_reg[0].is_load &&
                    stage_reg[0].wr_en && (stage_reg[0].wr_reg != '0) && (rs_hit || rt_hit);

  assign flush = br_taken && stage_reg[BR_STAGE].valid;
  assign stall = load_use && !flush;

  assign stage_next[0] = (id_valid && !stall && !flush) ? id_rec : BUBBLE;

  // Stages younger than the branch are squashed before they shift onward.
  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
    assign stage_next[gi] = (flush && ((gi - 1) < BR_STAGE)) ? BUBBLE : stage_reg[gi-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stage_reg[k] <= BUBBLE;
    end else begin
      stage_reg <= stage_next;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    assign stage_valid[gi] = stage_reg[gi].valid;
  end

  fwd_select #(
    .DEPTH (DEPTH),
    .SW    (SW)
  ) u_fwd_a (
    .stages (stage_reg),
    .src    (rs_ext),
    .sel    (fwd_a_sel)
  );

  fwd_select #(
    .DEPTH (DEPTH),
    .SW    (SW)
  ) u_fwd_b (
    .stages (stage_reg),
    .src    (rt_ext),
    .sel    (fwd_b_sel)
  );

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (flush && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; define HAZARD_PERF_EN to also check the counters.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int DEPTH  = 3;
  localparam int SW     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load;
  logic [REG_AW-1:0] id_rs, id_rt, id_wr_reg;
  logic              br_taken;
  logic              stall, flush;
  logic [SW-1:0]     fwd_a_sel, fwd_b_sel;
  logic [DEPTH-1:0]  stage_valid;
`ifdef HAZARD_PERF_EN
  logic [31:0]       stall_cnt, flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_AW   (REG_AW),
    .DEPTH    (DEPTH),
    .BR_STAGE (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_wr_en    (id_wr_en),
    .id_is_load  (id_is_load),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_wr_reg   (id_wr_reg),
    .br_taken    (br_taken),
    .stall       (stall),
    .flush       (flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stage_valid (stage_valid)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  task automatic set_id(input logic v, input logic urs, input logic urt, input logic we,
                        input logic ld, input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                        input logic [REG_AW-1:0] wr);
    id_valid = v; id_uses_rs = urs; id_uses_rt = urt; id_wr_en = we; id_is_load = ld;
    id_rs = rs; id_rt = rt; id_wr_reg = wr;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    br_taken = 1'b0;
    repeat (DEPTH) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_id(1, 1, 1, 1, 1, 3, 3, 3);
    br_taken = 1'b1;
    @(negedge clk); #1;
    checks++; if (stage_valid !== 3'b000) begin failures++; $display("FAIL rst_stage_valid: got %b expected %b", stage_valid, 3'b000); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall: got %b expected %b", stall, 1'b0); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rst_flush: got %b expected %b", flush, 1'b0); end
    checks++; if (fwd_a_sel !== 2'd0) begin failures++; $display("FAIL rst_fwd_a: got %0d expected %0d", fwd_a_sel, 0); end
    checks++; if (fwd_b_sel !== 2'd0) begin failures++; $display("FAIL rst_fwd_b: got %0d expected %0d", fwd_b_sel, 0); end
    rst = 1'b0; #1;
    checks++; if (stage_valid !== 3'b000) begin failures++; $display("FAIL post_rst_stage_valid: got %b expected %b", stage_valid, 3'b000); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL post_rst_stall: got %b expected %b", stall, 1'b0); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL post_rst_flush: got %b expected %b", flush, 1'b0); end
    @(negedge clk); #1;
    checks++; if (stage_valid !== 3'b001) begin failures++; $display("FAIL post_rst_load: got %b expected %b", stage_valid, 3'b001); end
    $display("test_reset done");
    drain();
  endtask

  task automatic test_fwd_ex();
    set_id(1, 1, 1, 1, 0, 1, 2, 3);
    #1;
    checks++; if (fwd_a_sel !== 2'd0) begin failures++; $display("FAIL ex_empty_fwd_a: got %0d expected %0d", fwd_a_sel, 0); end
    @(negedge clk);
    set_id(1, 1, 1, 1, 0, 3, 7, 8);
    #1;
    checks++; if (fwd_a_sel !== 2'd1) begin failures++; $display("FAIL ex_fwd_a: got %0d expected %0d", fwd_a_sel, 1); end
    checks++; if (fwd_b_sel !== 2'd0) begin failures++; $display("FAIL ex_fwd_b: got %0d expected %0d", fwd_b_sel, 0); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ex_stall: got %b expected %b", stall, 1'b0); end
    checks++; if (stage_valid !== 3'b001) begin failures++; $display("FAIL ex_stage_valid: got %b expected %b", stage_valid, 3'b001); end
    $display("test_fwd_ex done");
    drain();
  endtask

  task automatic test_load_use();
    set_id(1, 1, 0, 1, 1, 1, 0, 5);
    @(negedge clk);
    set_id(1, 1, 1, 1, 0, 9, 5, 10);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall: got %b expected %b", stall, 1'b1); end
    checks++; if (fwd_b_sel !== 2'd0) begin failures++; $display("FAIL lu_fwd_b_ex: got %0d expected %0d", fwd_b_sel, 0); end
    @(negedge clk); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall_released: got %b expected %b", stall, 1'b0); end
    checks++; if (fwd_b_sel !== 2'd2) begin failures++; $display("FAIL lu_fwd_b_mem: got %0d expected %0d", fwd_b_sel, 2); end
    checks++; if (stage_valid !== 3'b010) begin failures++; $display("FAIL lu_bubble: got %b expected %b", stage_valid, 3'b010); end
    @(negedge clk); #1;
    checks++; if (stage_valid !== 3'b101) begin failures++; $display("FAIL lu_issue: got %b expected %b", stage_valid, 3'b101); end
    checks++; if (fwd_b_sel !== 2'd3) begin failures++; $display("FAIL lu_fwd_b_wb: got %0d expected %0d", fwd_b_sel, 3); end
    $display("test_load_use done");
    drain();
  endtask

  task automatic test_youngest();
    set_id(1, 1, 1, 1, 0, 1, 2, 4);
    @(negedge clk);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    set_id(1, 1, 1, 1, 0, 5, 6, 4);
    @(negedge clk);
    set_id(1, 1, 1, 0, 0, 4, 4, 0);
    #1;
    checks++; if (fwd_a_sel !== 2'd1) begin failures++; $display("FAIL yw_fwd_a: got %0d expected %0d", fwd_a_sel, 1); end
    checks++; if (fwd_b_sel !== 2'd1) begin failures++; $display("FAIL yw_fwd_b: got %0d expected %0d", fwd_b_sel, 1); end
    checks++; if (stage_valid !== 3'b101) begin failures++; $display("FAIL yw_stage_valid: got %b expected %b", stage_valid, 3'b101); end
    @(negedge clk);
    set_id(1, 1, 0, 0, 0, 4, 0, 0);
    #1;
    checks++; if (fwd_a_sel !== 2'd2) begin failures++; $display("FAIL yw_fwd_a_mem: got %0d expected %0d", fwd_a_sel, 2); end
    @(negedge clk); #1;
    checks++; if (fwd_a_sel !== 2'd3) begin failures++; $display("FAIL yw_fwd_a_wb: got %0d expected %0d", fwd_a_sel, 3); end
    $display("test_youngest done");
    drain();
  endtask

  task automatic test_r0();
    set_id(1, 1, 1, 1, 0, 1, 2, 0);
    @(negedge clk);
    set_id(1, 1, 1, 1, 1, 0, 0, 0);
    #1;
    checks++; if (fwd_a_sel !== 2'd0) begin failures++; $display("FAIL r0_fwd_a: got %0d expected %0d", fwd_a_sel, 0); end
    checks++; if (fwd_b_sel !== 2'd0) begin failures++; $display("FAIL r0_fwd_b: got %0d expected %0d", fwd_b_sel, 0); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL r0_stall: got %b expected %b", stall, 1'b0); end
    @(negedge clk);
    set_id(1, 1, 1, 0, 0, 0, 0, 0);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL r0_load_stall: got %b expected %b", stall, 1'b0); end
    checks++; if (fwd_a_sel !== 2'd0) begin failures++; $display("FAIL r0_load_fwd_a: got %0d expected %0d", fwd_a_sel, 0); end
    $display("test_r0 done");
    drain();
  endtask

  task automatic test_flush();
    set_id(1, 1, 1, 0, 0, 1, 2, 0);
    @(negedge clk);
    set_id(1, 1, 0, 1, 1, 1, 0, 6);
    @(negedge clk);
    set_id(1, 1, 0, 0, 0, 6, 0, 0);
    br_taken = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL fl_pending_stall: got %b expected %b", stall, 1'b1); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL fl_no_flush: got %b expected %b", flush, 1'b0); end
    br_taken = 1'b1;
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL fl_flush: got %b expected %b", flush, 1'b1); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fl_stall_masked: got %b expected %b", stall, 1'b0); end
    @(negedge clk); #1;
    checks++; if (stage_valid !== 3'b100) begin failures++; $display("FAIL fl_stage_valid: got %b expected %b", stage_valid, 3'b100); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL fl_br_stage_empty: got %b expected %b", flush, 1'b0); end
    checks++; if (fwd_a_sel !== 2'd0) begin failures++; $display("FAIL fl_squashed_fwd: got %0d expected %0d", fwd_a_sel, 0); end
    $display("test_flush done");
    drain();
  endtask

  task automatic test_reset_mid();
    set_id(1, 1, 1, 1, 0, 1, 2, 11);
    @(negedge clk);
    set_id(1, 1, 1, 1, 0, 1, 2, 12);
    @(negedge clk);
    set_id(1, 1, 1, 1, 0, 1, 2, 13);
    @(negedge clk);
    set_id(1, 1, 1, 0, 0, 12, 11, 0);
    #1;
    checks++; if (stage_valid !== 3'b111) begin failures++; $display("FAIL rm_full: got %b expected %b", stage_valid, 3'b111); end
    checks++; if (fwd_a_sel !== 2'd2) begin failures++; $display("FAIL rm_fwd_a: got %0d expected %0d", fwd_a_sel, 2); end
    checks++; if (fwd_b_sel !== 2'd3) begin failures++; $display("FAIL rm_fwd_b: got %0d expected %0d", fwd_b_sel, 3); end
`ifdef HAZARD_PERF_EN
    checks++; if (stall_cnt !== 32'd1) begin failures++; $display("FAIL rm_stall_cnt: got %0d expected %0d", stall_cnt, 1); end
    checks++; if (flush_cnt !== 32'd1) begin failures++; $display("FAIL rm_flush_cnt: got %0d expected %0d", flush_cnt, 1); end
`endif
    rst = 1'b1;
    #1;
    checks++; if (stage_valid !== 3'b000) begin failures++; $display("FAIL rm_cleared: got %b expected %b", stage_valid, 3'b000); end
    checks++; if (fwd_a_sel !== 2'd0) begin failures++; $display("FAIL rm_fwd_a_rst: got %0d expected %0d", fwd_a_sel, 0); end
    checks++; if (fwd_b_sel !== 2'd0) begin failures++; $display("FAIL rm_fwd_b_rst: got %0d expected %0d", fwd_b_sel, 0); end
`ifdef HAZARD_PERF_EN
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL rm_stall_cnt_rst: got %0d expected %0d", stall_cnt, 0); end
    checks++; if (flush_cnt !== 32'd0) begin failures++; $display("FAIL rm_flush_cnt_rst: got %0d expected %0d", flush_cnt, 0); end
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (stage_valid !== 3'b000) begin failures++; $display("FAIL rm_after_rst: got %b expected %b", stage_valid, 3'b000); end
    checks++; if (fwd_a_sel !== 2'd0) begin failures++; $display("FAIL rm_after_fwd_a: got %0d expected %0d", fwd_a_sel, 0); end
    $display("test_reset_mid done");
    drain();
  endtask

  initial begin
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    br_taken = 1'b0;
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_youngest();
    test_r0();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter DEPTH, default 3, number of tracked post-decode stages (index 0 = EX, 1 = MEM, 2 = WB).
REQ-003 SHALL have parameter BR_STAGE, default 1, the stage index where a branch resolves; legal range 0..DEPTH-1.
REQ-004 SHALL have port clk, input, 1, the single clock (rising edge).
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load: inputs, 1 bit each, decode-stage instruction attributes.
REQ-007 SHALL have ports id_rs, id_rt, id_wr_reg: inputs, REG_AW each, decode-stage source and destination registers.
REQ-008 SHALL have port br_taken, input, 1, taken branch or jump resolved in stage BR_STAGE.
REQ-009 SHALL have ports stall and flush, outputs, 1 bit each; stall holds PC and the IF/ID register, flush clears younger instructions.
REQ-010 SHALL have ports fwd_a_sel and fwd_b_sel, outputs, SW = $clog2(DEPTH+1) bits each; 0 = register file, k = result of stage k-1.
REQ-011 SHALL have port stage_valid, output, DEPTH bits, valid bit per tracked stage.

Function
REQ-012 SHALL keep one record {valid, wr_en, wr_reg, is_load} per stage in a DEPTH-deep shift register.
REQ-013 SHALL, each clock edge, shift stage[k] <= stage[k-1] for k = 1..DEPTH-1; stage[DEPTH-1] retires.
REQ-014 SHALL load stage[0] with the decode record when id_valid=1, stall=0 and flush=0; otherwise stage[0] SHALL become a bubble (valid=0).
REQ-015 SHALL assert stall combinationally when all of the following hold: stage[0] is valid, is_load=1, wr_en=1, wr_reg!=0, and wr_reg equals a used source (rs with id_uses_rs, or rt with id_uses_rt) of a valid decode instruction.
REQ-016 SHALL compute each fwd sel from the lowest-index stage k that matches the source register, with valid=1, wr_en=1, wr_reg!=0, and that is not a load in stage 0; the output SHALL be k+1, else 0.
REQ-017 SHALL never forward register 0; a source of 0 SHALL always give sel 0.
REQ-018 SHALL drive flush = br_taken && stage[BR_STAGE].valid.
REQ-019 SHALL, on flush, invalidate stages 0..BR_STAGE-1 at the next edge (before shifting) and insert a bubble into stage 0.
REQ-020 SHALL let flush take priority over stall; stall SHALL be forced to 0 while flush=1.
REQ-021 SHALL produce its outputs with zero latency; they are combinational from stage records and decode inputs, and records update one cycle later.
REQ-022 SHALL resolve simultaneous matches in several stages to the youngest (lowest index) producer.

Reset
REQ-023 SHALL, while rst=1, asynchronously clear all records to valid=0, wr_en=0, wr_reg=0, is_load=0.
REQ-024 SHALL hold stage_valid=0, stall=0, flush=0, fwd_a_sel=0 and fwd_b_sel=0 during reset and in the first cycle after it, regardless of decode inputs.
REQ-025 SHALL discard all in-flight records when reset is asserted mid-operation; no partial flush or stall state SHALL persist.

Configuration
REQ-026 SHALL, with macro HAZARD_PERF_EN defined, add 32-bit outputs stall_cnt and flush_cnt that increment on each cycle where stall or flush is 1, saturate at 0xFFFFFFFF, and reset to 0.
REQ-027 SHALL, without HAZARD_PERF_EN, omit those ports and counters; all other behaviour SHALL be identical.

Structure
REQ-028 SHALL place the stage-record typedef, the bubble constant and the SW width function in shared package mips_pipe_pkg.
REQ-029 SHALL use one sub-module, fwd_select, instantiated twice (rs and rt), implementing REQ-016/017 for one source.

Verification
REQ-030 SHALL cover this scenario: add r3 in EX, then decode of sub using rs=r3 -> fwd_a_sel=1, stall=0.
REQ-031 SHALL cover this scenario: lw r5 in EX, then decode using rt=r5 -> stall=1 for exactly 1 cycle, then fwd_b_sel=2 with the load in MEM.
REQ-032 SHALL cover this scenario: r4 written in both EX and WB, then decode with rs=r4 -> fwd_a_sel=1 (youngest wins).
REQ-033 SHALL cover this scenario: writer to r0 in EX, then decode with rs=r0 -> fwd_a_sel=0, stall=0.
REQ-034 SHALL cover this scenario: br_taken=1 with a valid stage[1] while a load-use stall is pending -> flush=1, stall=0, and next cycle stage_valid=3'b100.
REQ-035 SHALL cover this scenario: rst pulsed mid-stream with 3 valid stages -> stage_valid=0 immediately; with HAZARD_PERF_EN, counters read 0.
